instruction_fetch_unit: RTL and testbench

//  Fetch stage feeding the single-cycle execute datapath: owns the PC, reads instruction

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 115 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - fetch stage bus: imem req/ack, redirect input, fetch output handshake
interface instruction_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] pcNext;
   logic        misaligned_fault;

   modport master (
      output imem_req, imem_addr, fetch_valid, instruction, pc, pcNext, misaligned_fault,
      input  imem_ack, imem_rdata, redirect_valid, redirect_pc, fetch_ready
   );

   modport slave (
      input  imem_req, imem_addr, fetch_valid, instruction, pc, pcNext, misaligned_fault,
      output imem_ack, imem_rdata, redirect_valid, redirect_pc, fetch_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch stage: owns the PC, reads imem over req/ack, presents instructions to execute
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   instruction_fetch_unit_if.master bus
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_next_q;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pending_q, pending_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        redirect_bad;
   logic [31:0] drain_target;

   assign redirect_bad = bus.redirect_pc[1:0] != 2'b00;
   // A redirect arriving in the ack cycle of a drain is newer than the pending one.
   assign drain_target = bus.redirect_valid ? bus.redirect_pc : pending_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      pending_d = pending_q;
      valid_d   = valid_q;
      fault_d   = fault_q;
      case (state_q)
         FETCH: begin
            if (bus.imem_ack) begin
               if (bus.redirect_valid) begin
                  if (redirect_bad) state_d = FAULT;
                  else              pc_d    = bus.redirect_pc;
               end else begin
                  instr_d = bus.imem_rdata;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            end else if (bus.redirect_valid) begin
               pending_d = bus.redirect_pc;
               state_d   = DRAIN;
            end
         end
         HOLD: begin
            if (bus.redirect_valid) begin
               valid_d = 1'b0;
               if (redirect_bad) begin
                  state_d = FAULT;
               end else begin
                  pc_d    = bus.redirect_pc;
                  state_d = FETCH;
               end
            end else if (bus.fetch_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 32'd4;
               state_d = FETCH;
            end
         end
         DRAIN: begin
            if (bus.imem_ack) begin
               if (drain_target[1:0] != 2'b00) begin
                  state_d = FAULT;
               end else begin
                  pc_d    = drain_target;
                  state_d = FETCH;
               end
            end else if (bus.redirect_valid) begin
               pending_d = bus.redirect_pc;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
      endcase
      if (state_d == FAULT) begin
         fault_d = 1'b1;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         pc_next_q <= RESET_PC + 32'd4;
         instr_q   <= NOP;
         pending_q <= 32'h0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pc_next_q <= pc_d + 32'd4;
         instr_q   <= instr_d;
         pending_q <= pending_d;
         valid_q   <= valid_d;
         fault_q   <= fault_d;
      end
   end

   // Request is held off while reset is asserted so it first rises after release.
   assign bus.imem_req         = !reset && (state_q == FETCH || state_q == DRAIN);
   assign bus.imem_addr        = pc_q;
   assign bus.fetch_valid      = valid_q;
   assign bus.instruction      = instr_q;
   assign bus.pc               = pc_q;
   assign bus.pcNext           = pc_next_q;
   assign bus.misaligned_fault = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit with a delivery scoreboard
module tb_instruction_fetch_unit;
   logic clk = 1'b0;
   logic reset;
   logic reset2;

   always #5 clk = ~clk;

   instruction_fetch_unit_if bus ();
   instruction_fetch_unit_if bus2 ();

   instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset), .bus(bus.master)
   );
   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .reset(reset2), .bus(bus2.master)
   );

   int checks = 0;
   int passes = 0;
   int mem_wait = 0;
   int mem_wait2 = 0;
   logic [31:0] exp_q[$];

   // Memory models: return the address as the instruction after mem_wait wait cycles.
   initial begin : mem1
      int cnt;
      cnt = 0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      forever begin
         @(negedge clk); #1;
         if (bus.imem_req) begin
            if (cnt < mem_wait) begin bus.imem_ack = 1'b0; cnt++; end
            else begin bus.imem_ack = 1'b1; bus.imem_rdata = bus.imem_addr; cnt = 0; end
         end else begin
            bus.imem_ack = 1'b0; cnt = 0;
         end
      end
   end

   initial begin : mem2
      int cnt;
      cnt = 0;
      bus2.imem_ack = 1'b0;
      bus2.imem_rdata = 32'h0;
      forever begin
         @(negedge clk); #1;
         if (bus2.imem_req) begin
            if (cnt < mem_wait2) begin bus2.imem_ack = 1'b0; cnt++; end
            else begin bus2.imem_ack = 1'b1; bus2.imem_rdata = bus2.imem_addr; cnt = 0; end
         end else begin
            bus2.imem_ack = 1'b0; cnt = 0;
         end
      end
   end

   // Each new presentation on the main instance is popped and compared against the scoreboard.
   initial begin : monitor
      logic prev;
      logic [31:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.fetch_valid && !prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL delivery: unexpected pc=%h instr=%h, scoreboard empty", bus.pc, bus.instruction);
            end else begin
               e = exp_q.pop_front();
               if (bus.pc !== e || bus.pcNext !== e + 32'd4 || bus.instruction !== e)
                  $display("FAIL delivery: pc=%h pcNext=%h instr=%h, expected pc=%h pcNext=%h instr=%h",
                           bus.pc, bus.pcNext, bus.instruction, e, e + 32'd4, e);
               else passes++;
            end
         end
         prev = bus.fetch_valid;
      end
   end

   task automatic test_reset();
      bus.fetch_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.fetch_valid); else passes++;
      checks++; if (bus.pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", bus.pc); else passes++;
      checks++; if (bus.pcNext !== 32'h4) $display("FAIL reset_pcnext: got %h expected 4", bus.pcNext); else passes++;
      checks++; if (bus.instruction !== 32'h13) $display("FAIL reset_instr: got %h expected 13", bus.instruction); else passes++;
      checks++; if (bus.misaligned_fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", bus.misaligned_fault); else passes++;
      checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.imem_req); else passes++;
      exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8); exp_q.push_back(32'hC);
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      logic exp_v;
      #2;
      checks++; if (bus.imem_req !== 1'b1) $display("FAIL first_req: got %b expected 1", bus.imem_req); else passes++;
      checks++; if (bus.imem_addr !== 32'h0) $display("FAIL first_addr: got %h expected 0", bus.imem_addr); else passes++;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         exp_v = (i % 2 == 0);
         checks++; if (bus.fetch_valid !== exp_v) $display("FAIL seq_valid[%0d]: got %b expected %b", i, bus.fetch_valid, exp_v); else passes++;
         if (i == 6) bus.fetch_ready = 1'b0;
      end
   endtask

   task automatic test_wait_states();
      @(negedge clk);
      mem_wait = 3;
      bus.fetch_ready = 1'b1;
      exp_q.push_back(32'h10);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) $display("FAIL wait_hold[%0d]: got req=%b addr=%h expected req=1 addr=10", i, bus.imem_req, bus.imem_addr); else passes++;
         checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL wait_valid[%0d]: got %b expected 0", i, bus.fetch_valid); else passes++;
      end
      @(negedge clk);
      checks++; if (bus.fetch_valid !== 1'b1) $display("FAIL wait_deliver: got %b expected 1", bus.fetch_valid); else passes++;
      bus.fetch_ready = 1'b0;
      mem_wait = 0;
   endtask

   task automatic test_redirect_hold();
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h100;
      bus.fetch_ready = 1'b1;
      exp_q.push_back(32'h100);
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.fetch_ready = 1'b0;
      checks++; if (bus.fetch_valid !== 1'b0) $display("FAIL rhold_valid: got %b expected 0", bus.fetch_valid); else passes++;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) $display("FAIL rhold_addr: got req=%b addr=%h expected req=1 addr=100", bus.imem_req, bus.imem_addr); else passes++;
      @(negedge clk);
      checks++; if (bus.fetch_valid !== 1'b1 || bus.pc !== 32'h100) $display("FAIL rhold_pc: got valid=%b pc=%h expected valid=1 pc=100", bus.fetch_valid, bus.pc); else passes++;
   endtask

   task automatic test_redirect_drain();
      bit seen;
      @(negedge clk);
      mem_wait = 3;
      bus.fetch_ready = 1'b1;
      @(negedge clk);
      bus.fetch_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h200;
      checks++; if (bus.imem_addr !== 32'h104) $display("FAIL drain_start_addr: got %h expected 104", bus.imem_addr); else passes++;
      @(negedge clk);
      bus.redirect_pc = 32'h300;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h104) $display("FAIL drain_hold: got req=%b addr=%h expected req=1 addr=104", bus.imem_req, bus.imem_addr); else passes++;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      mem_wait = 0;
      exp_q.push_back(32'h300);
      @(negedge clk);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) $display("FAIL drain_next: got req=%b addr=%h expected req=1 addr=300", bus.imem_req, bus.imem_addr); else passes++;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus.fetch_valid;
      end
      checks++; if (!seen) $display("FAIL drain_timeout: got no fetch_valid expected one within 8 cycles"); else passes++;
   endtask

   task automatic test_misaligned();
      bit seen;
      @(negedge clk);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h102;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      bus.fetch_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++; if (bus.misaligned_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.fetch_valid !== 1'b0)
            $display("FAIL fault_sticky[%0d]: got fault=%b req=%b valid=%b expected 1 0 0", i, bus.misaligned_fault, bus.imem_req, bus.fetch_valid);
         else passes++;
         @(negedge clk);
      end
      reset = 1'b1;
      bus.fetch_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.pc !== 32'h0 || bus.misaligned_fault !== 1'b0 || bus.fetch_valid !== 1'b0) $display("FAIL fault_reset: got pc=%h fault=%b valid=%b expected 0 0 0", bus.pc, bus.misaligned_fault, bus.fetch_valid); else passes++;
      exp_q.push_back(32'h0);
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus.fetch_valid;
      end
      checks++; if (!seen) $display("FAIL fault_restart: got no fetch_valid expected one within 8 cycles"); else passes++;
      mem_wait = 2;
      bus.fetch_ready = 1'b1;
      @(negedge clk);
      bus.fetch_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h6;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || bus.misaligned_fault !== 1'b0)
         $display("FAIL fault_drain: got req=%b addr=%h fault=%b expected 1 4 0", bus.imem_req, bus.imem_addr, bus.misaligned_fault);
      else passes++;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus.misaligned_fault;
      end
      checks++; if (!seen || bus.imem_req !== 1'b0) $display("FAIL fault_after_drain: got fault=%b req=%b expected 1 0", seen, bus.imem_req); else passes++;
      reset = 1'b1;
      mem_wait = 0;
      exp_q.push_back(32'h0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      bit seen;
      @(negedge clk);
      checks++; if (bus2.pc !== 32'hFFFF_FFFC || bus2.pcNext !== 32'h0 || bus2.imem_req !== 1'b0)
         $display("FAIL wrap_reset: got pc=%h pcNext=%h req=%b expected fffffffc 0 0", bus2.pc, bus2.pcNext, bus2.imem_req);
      else passes++;
      reset2 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = bus2.fetch_valid;
      end
      checks++; if (!seen) $display("FAIL wrap_timeout: got no fetch_valid expected one within 8 cycles"); else passes++;
      checks++; if (bus2.pc !== 32'hFFFF_FFFC || bus2.pcNext !== 32'h0 || bus2.instruction !== 32'hFFFF_FFFC)
         $display("FAIL wrap_deliver: got pc=%h pcNext=%h instr=%h expected fffffffc 0 fffffffc", bus2.pc, bus2.pcNext, bus2.instruction);
      else passes++;
      bus2.fetch_ready = 1'b1;
      @(negedge clk);
      bus2.fetch_ready = 1'b0;
      mem_wait2 = 3;
      bus2.redirect_valid = 1'b1;
      bus2.redirect_pc = 32'h40;
      checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0 || bus2.misaligned_fault !== 1'b0)
         $display("FAIL wrap_addr: got req=%b addr=%h fault=%b expected 1 0 0", bus2.imem_req, bus2.imem_addr, bus2.misaligned_fault);
      else passes++;
      @(negedge clk);
      bus2.redirect_valid = 1'b0;
      checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'h0) $display("FAIL wrap_drain: got req=%b addr=%h expected 1 0", bus2.imem_req, bus2.imem_addr); else passes++;
      reset2 = 1'b1;
      @(negedge clk);
      checks++; if (bus2.pc !== 32'hFFFF_FFFC || bus2.fetch_valid !== 1'b0 || bus2.imem_req !== 1'b0)
         $display("FAIL wrap_mid_reset: got pc=%h valid=%b req=%b expected fffffffc 0 0", bus2.pc, bus2.fetch_valid, bus2.imem_req);
      else passes++;
      reset2 = 1'b0;
      mem_wait2 = 0;
      #2;
      checks++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_refetch: got req=%b addr=%h expected 1 fffffffc", bus2.imem_req, bus2.imem_addr); else passes++;
   endtask

   initial begin
      reset = 1'b1;
      reset2 = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.fetch_ready = 1'b0;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc = 32'h0;
      bus2.fetch_ready = 1'b0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_redirect_hold();
      test_redirect_drain();
      test_misaligned();
      test_wrap();
      repeat (4) @(negedge clk);
      checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size()); else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
